// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and nibble width.
package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4bit.sv
// 4-bit ripple-carry adder; purely combinational nibble datapath.
module adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end

endmodule

// File: rtl/adder_nibble_seq.sv
// WIDTH-bit add/sub on one shared 4-bit adder, LSB nibble first; done pulses NIB+1 cycles after start.
// No backpressure: start is only accepted in IDLE or DONE and is ignored while busy.
module adder_nibble_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt, b_eff;
  logic [IDX_W-1:0] idx;
  logic             carry, a_msb, b_msb;
  logic             load, step, last;
  logic [3:0]       nib_sum;
  logic             nib_co;

  adder4bit u_adder4bit (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_co)
  );

  // Subtraction is a + ~b + ~borrow_in, so invert both at capture time.
  assign b_eff   = sub ? ~b : b;
  assign res_nxt = (res_sh >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b_eff;
      carry <= sub ^ c_in;
      idx   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b_eff[WIDTH-1];
    end else if (step) begin
      a_sh   <= a_sh >> NIB_W;
      b_sh   <= b_sh >> NIB_W;
      carry  <= nib_co;
      idx    <= idx + 1'b1;
      res_sh <= res_nxt;
      if (last) begin
        sum   <= res_nxt;
        c_out <= nib_co;
        ovf   <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Bench for adder_nibble_seq at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_adder_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic        sub = 1'b0;
  logic        c_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;
  logic        busy16, done16, co16, ov16;
  logic [15:0] sum16;

  adder_nibble_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .ovf(ov8)
  );

  adder_nibble_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy16), .done(done16), .sum(sum16), .c_out(co16), .ovf(ov16)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        ob[2], od[2], oc[2], oo[2];
  logic [15:0] osum[2];
  assign ob[0] = busy8;  assign od[0] = done8;  assign oc[0] = co8;  assign oo[0] = ov8;
  assign ob[1] = busy16; assign od[1] = done16; assign oc[1] = co16; assign oo[1] = ov16;
  assign osum[0] = {8'h00, sum8};
  assign osum[1] = sum16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full-width arithmetic reference: modular sum, carry/no-borrow, signed overflow.
  function automatic void ref_op(input int w, input logic s, input logic [15:0] x,
                                 input logic [15:0] y, input logic ci,
                                 output logic [15:0] r, output logic co, output logic ov);
    longint mask, xa, ya, t;
    logic sx, sy, sr;
    mask = (longint'(1) << w) - 1;
    xa   = longint'(x) & mask;
    ya   = longint'(y) & mask;
    if (!s) begin
      t  = xa + ya + longint'(ci);
      co = ((t >> w) & 1) != 0;
    end else begin
      t  = xa - ya - longint'(ci);
      co = (t >= 0);
    end
    r  = 16'(t & mask);
    sx = x[w-1];
    sy = y[w-1];
    sr = r[w-1];
    ov = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
  endfunction

  // Model: result due NIB cycles after the accept edge; busy in between; outputs held after.
  bit          mv = 0;
  bit          pend[2];
  int          acc[2];
  logic [15:0] rs[2], hs[2];
  logic        rc[2], ro[2], hc[2], ho[2];
  int          nib[2] = '{2, 4};
  int          wid[2] = '{8, 16};

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; acc[i] = 0; rs[i] = '0; hs[i] = '0;
      rc[i] = 0; ro[i] = 0; hc[i] = 0; ho[i] = 0;
    end
  end

  always @(negedge clk) begin
    bit eb, ed;
    for (int i = 0; i < 2; i++) begin
      eb = pend[i] && (cyc >= acc[i]) && (cyc < acc[i] + nib[i]);
      ed = pend[i] && (cyc == acc[i] + nib[i]);
      if (ed) begin
        hs[i] = rs[i]; hc[i] = rc[i]; ho[i] = ro[i];
      end
      if (mv) begin
        check($sformatf("busy_w%0d", wid[i]), 32'(ob[i]), 32'(eb));
        check($sformatf("done_w%0d", wid[i]), 32'(od[i]), 32'(ed));
        check($sformatf("sum_w%0d", wid[i]), 32'(osum[i]), 32'(hs[i]));
        check($sformatf("c_out_w%0d", wid[i]), 32'(oc[i]), 32'(hc[i]));
        check($sformatf("ovf_w%0d", wid[i]), 32'(oo[i]), 32'(ho[i]));
      end
      if (rst) begin
        pend[i] = 0; hs[i] = '0; hc[i] = 0; ho[i] = 0;
      end else if (mv && start[i] && !eb) begin
        pend[i] = 1;
        acc[i]  = cyc + 1;
        ref_op(wid[i], sub, a, b, c_in, rs[i], rc[i], ro[i]);
      end
    end
    if (rst) mv = 1;
  end

  task automatic issue(input int i, input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic ci);
    sub = s; a = x; b = y; c_in = ci; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim, output int lat, output int nbusy,
                           output logic [15:0] s, output logic co, output logic ov);
    lat = lim; nbusy = 0; s = '0; co = 0; ov = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (ob[i]) nbusy++;
      if (od[i]) begin
        lat = k; s = osum[i]; co = oc[i]; ov = oo[i];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int          lat, nb;
  logic [15:0] rsum;
  logic        rco, rov;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_c_out", 32'(co8), 32'd0);
    check("rst_ovf", 32'(ov8), 32'd0);
    @(posedge clk); #1;

    issue(0, 1'b0, 16'h003A, 16'h0047, 1'b0);
    wait_done(0, 10, lat, nb, rsum, rco, rov);
    check("add_lat", 32'(lat), 32'd2);
    check("add_busy_cycles", 32'(nb), 32'd2);
    check("add_sum", 32'(rsum), 32'h81);
    check("add_c_out", 32'(rco), 32'd0);
    check("add_ovf", 32'(rov), 32'd1);

    issue(0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
    wait_done(0, 10, lat, nb, rsum, rco, rov);
    check("ripple_sum", 32'(rsum), 32'h00);
    check("ripple_c_out", 32'(rco), 32'd1);
    check("ripple_ovf", 32'(rov), 32'd0);

    issue(0, 1'b1, 16'h0050, 16'h0020, 1'b0);
    wait_done(0, 10, lat, nb, rsum, rco, rov);
    check("sub_sum", 32'(rsum), 32'h30);
    check("sub_c_out", 32'(rco), 32'd1);
    check("sub_ovf", 32'(rov), 32'd0);

    issue(0, 1'b1, 16'h0020, 16'h0050, 1'b0);
    wait_done(0, 10, lat, nb, rsum, rco, rov);
    check("borrow_sum", 32'(rsum), 32'hD0);
    check("borrow_c_out", 32'(rco), 32'd0);

    // Starts during RUN are ignored; a start held in the DONE cycle chains immediately.
    issue(0, 1'b0, 16'h0011, 16'h0022, 1'b0);
    a = 16'h0077; b = 16'h0077; start[0] = 1'b1;
    @(posedge clk); #1;
    a = 16'h0066; b = 16'h0099;
    @(posedge clk); #1;
    a = 16'h0005; b = 16'h0006;
    @(negedge clk);
    check("ignore_done", 32'(done8), 32'd1);
    check("ignore_sum", 32'(sum8), 32'h33);
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, 10, lat, nb, rsum, rco, rov);
    check("b2b_gap", 32'(lat + 1), 32'd3);
    check("b2b_sum", 32'(rsum), 32'h0B);

    issue(0, 1'b0, 16'h003A, 16'h0047, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_c_out", 32'(co8), 32'd0);
    check("midrst_ovf", 32'(ov8), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done8), 32'd0);
    end
    @(posedge clk); #1;

    issue(1, 1'b0, 16'h1234, 16'h0FFF, 1'b1);
    wait_done(1, 12, lat, nb, rsum, rco, rov);
    check("w16_lat", 32'(lat), 32'd4);
    check("w16_busy_cycles", 32'(nb), 32'd4);
    check("w16_sum", 32'(rsum), 32'h2234);
    check("w16_c_out", 32'(rco), 32'd0);

    for (int n = 0; n < 400; n++) begin
      start[0] = 1'($urandom_range(0, 1));
      start[1] = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      c_in     = 1'($urandom_range(0, 1));
      a        = 16'($urandom);
      b        = 16'($urandom);
      rst      = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    start = 2'b00;
    repeat (10) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_nibble_seq.md
Name: adder_nibble_seq

Overview:
- Sequencer that performs a WIDTH-bit add or subtract on one shared 4-bit ripple adder (adder4bit), one nibble per clock, LSB nibble first.
- Holds the carry between nibbles in a register and presents a registered result with a start/busy/done handshake.
- Sits between a requesting controller and the existing 4-bit adder datapath, replacing a wide combinational adder where area matters.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready for a new operation
- sub  in  1  0 = a+b+c_in; 1 = a-b-c_in (c_in acts as borrow-in)
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- c_in  in  1  carry-in / borrow-in, captured on accepted start
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  single-cycle pulse; result valid
- sum  out  WIDTH  registered result; stable from the done pulse until the next done pulse
- c_out  out  1  final carry (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow of the result

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, c_out=0, ovf=0.
  - Nibble index, carry register and operand shift registers are cleared.
  - An in-flight operation is abandoned and produces no done.
- States:
  - IDLE: busy=0, done=0. On start=1, capture operands and go to RUN.
  - RUN: busy=1, done=0. Each edge retires one nibble. After the edge that writes nibble NIB-1, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. If start=1, capture operands and go to RUN (back-to-back); otherwise go to IDLE.
- Capture on an accepted start:
  - A_sh = a; B_sh = sub ? ~b : b; carry = sub ? ~c_in : c_in; idx = 0.
  - Latch the operand MSBs: a[WIDTH-1] and B_sh[WIDTH-1].
- RUN cycle datapath:
  - The adder is driven with A_sh[3:0], B_sh[3:0] and carry.
  - At the edge: the adder sum nibble is shifted into the top of the result shift register; A_sh and B_sh shift right by 4; carry takes the adder c_out; idx increments.
- On the RUN-to-DONE edge:
  - sum is loaded from the result register.
  - c_out is loaded from the final adder c_out.
  - ovf = (a_msb == b_eff_msb) && (result_msb != a_msb).
- Latency:
  - start is sampled high at edge E0.
  - done is high in the cycle following edge E0+NIB.
  - Throughput with back-to-back starts: one result per NIB+1 cycles.
- start while busy=1 is ignored: no queueing, operands are not recaptured.
- a, b, sub and c_in may change freely after capture without affecting the result.
- Width rules: every add is modulo 2^WIDTH; the carry out of bit WIDTH-1 goes to c_out only.
- WIDTH=4 is legal: one RUN cycle.

Decomposition:
- Shared package (adder_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NIB_W = 4.
- One sub-module: instantiate the existing adder4bit unchanged as the nibble datapath.
- FSM, shift registers and carry register live in adder_nibble_seq.

Test Plan:
- WIDTH=8: sub=0, a=0x3A, b=0x47, c_in=0 -> sum=0x81, c_out=0, ovf=1; done exactly 2 edges after the start edge; busy high for 2 cycles.
- WIDTH=8: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0 (carry ripples across the nibble boundary).
- WIDTH=8: sub=1, a=0x50, b=0x20, c_in=0 -> sum=0x30, c_out=1, ovf=0; then a=0x20, b=0x50 -> sum=0xD0, c_out=0.
- WIDTH=8: start pulses during RUN with different a/b -> ignored; the first result is unchanged and only one done pulse occurs. Then start is held high in the DONE cycle -> the next operation begins immediately and its done arrives 3 cycles after the previous done.
- WIDTH=8: rst=1 at the second RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0, ovf=0; no done until a new start is issued.
- WIDTH=16: a=0x1234, b=0x0FFF, c_in=1 -> sum=0x2234, c_out=0; done 4 edges after start.
